// File: rtl/kb_ps2_ctrl.sv
// PS/2 keyboard receiver with a scan-code FIFO, exposed as a DATA/STATUS bus slave.
// Frames are checked for start, odd parity and stop before the byte is queued.
module kb_ps2_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 5000
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [1:0]  WLEN,
  input  logic        EN_N,
  output logic        READY,
  output logic [31:0] rdata,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  logic clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic fall, bit_in;

  // Synchronisers idle high so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall   = clk_d & ~clk_s2;
  assign bit_in = dat_s2;

  rx_state_t        state, state_nxt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             par_bit;
  logic [TW-1:0]    to_cnt;
  logic             timeout, shift_en, par_en, push_req, perr_set;

  assign timeout = (state != S_IDLE) && !fall && (to_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall && !bit_in) state_nxt = S_DATA;
      S_DATA:   if (timeout) state_nxt = S_IDLE;
                else if (fall && bit_idx == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (timeout) state_nxt = S_IDLE;
                else if (fall) state_nxt = S_STOP;
      S_STOP:   if (timeout || fall) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    shift_en = (state == S_DATA) && fall;
    par_en   = (state == S_PARITY) && fall;
    push_req = (state == S_STOP) && fall && bit_in && (^{shift, par_bit});
    perr_set = (state == S_STOP) && fall && !(bit_in && (^{shift, par_bit}));
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == S_IDLE || fall || timeout) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + TW'(1);
      if (state == S_IDLE)  bit_idx <= '0;
      else if (shift_en)    bit_idx <= bit_idx + 3'd1;
      // LSB arrives first, so new bits enter at the top and walk down.
      if (shift_en) shift   <= {bit_in, shift[7:1]};
      if (par_en)   par_bit <= bit_in;
    end
  end

  // Bus handshake: an access starts when EN_N is low and the slave is armed;
  // READY pulses with rdata valid on the next cycle, and the slave re-arms
  // only after EN_N returns high, so a held request is served once.
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          armed, start, is_write, empty, full, pop, push;
  logic          ovf, perr, ovf_set, clr_ovf, clr_perr;
  logic [31:0]   rd_val;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:2];
  assign start    = !EN_N && armed;
  assign is_write = (WLEN != 2'b00);
  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = start && !is_write && (offset == 2'd0) && !empty;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign clr_ovf  = start && is_write && (offset == 2'd1) && wdata[0];
  assign clr_perr = start && is_write && (offset == 2'd1) && wdata[1];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (!is_write) begin
      case (offset)
        2'd0:    if (!empty) rd_val = {23'b0, 1'b1, mem[rd_ptr]};
        2'd1:    rd_val = {22'b0, perr, ovf, 8'(count)};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      irq    <= 1'b0;
      ovf    <= 1'b0;
      perr   <= 1'b0;
      armed  <= 1'b1;
      READY  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      irq   <= (count_nxt != '0);
      // A set event in the same cycle overrides a software clear.
      if (ovf_set)       ovf <= 1'b1;
      else if (clr_ovf)  ovf <= 1'b0;
      if (perr_set)      perr <= 1'b1;
      else if (clr_perr) perr <= 1'b0;
      if (EN_N)       armed <= 1'b1;
      else if (start) armed <= 1'b0;
      READY <= start;
      if (start) rdata <= rd_val;
    end
  end
endmodule

// File: tb/tb_kb_ps2_ctrl.sv
// Directed bench for kb_ps2_ctrl: PS/2 frame driver, bus driver, a queue-based
// model of the keyboard buffer and a per-cycle compare process.
module tb_kb_ps2_ctrl;
  localparam int DEPTH = 16;
  localparam int H     = 6;

  logic        clk;
  logic        RST_N;
  logic        ps2_clk;
  logic        ps2_data;
  logic [1:0]  offset;
  logic [31:0] wdata;
  logic [1:0]  WLEN;
  logic        EN_N;
  logic        READY;
  logic [31:0] rdata;
  logic        irq;

  kb_ps2_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(5000)) dut (
    .clk(clk), .RST_N(RST_N), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .offset(offset), .wdata(wdata), .WLEN(WLEN), .EN_N(EN_N),
    .READY(READY), .rdata(rdata), .irq(irq)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int valid_from = 0;
  bit frame_busy = 1'b0;
  logic [31:0] last_rdata = '0;

  // model state
  logic [7:0]  model_q[$];
  bit          m_ovf = 1'b0;
  bit          m_perr = 1'b0;
  logic [31:0] exp_q[$];
  int          ready_cyc_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%08h want=%08h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    bit exp_ready;
    logic [31:0] e;
    cyc = cyc + 1;
    if (!RST_N) begin
      chk("ready_in_reset", {31'b0, READY}, 32'd0);
      chk("irq_in_reset", {31'b0, irq}, 32'd0);
    end else begin
      exp_ready = (ready_cyc_q.size() > 0) && (ready_cyc_q[0] == cyc);
      chk("ready", {31'b0, READY}, {31'b0, exp_ready});
      if (exp_ready) begin
        void'(ready_cyc_q.pop_front());
        e = exp_q.pop_front();
        chk("rdata", rdata, e);
      end
      if (READY) last_rdata = rdata;
      if (!frame_busy && cyc >= valid_from)
        chk("irq", {31'b0, irq}, {31'b0, model_q.size() != 0});
    end
  end

  // driver tasks
  task automatic bus_start(input logic [1:0] off, input logic [1:0] wl, input logic [31:0] wd);
    logic [31:0] e;
    e = '0;
    if (wl == 2'b00) begin
      if (off == 2'd0 && model_q.size() > 0) e = 32'h100 | 32'(model_q.pop_front());
      else if (off == 2'd1) e = (32'(m_perr) << 9) | (32'(m_ovf) << 8) | 32'(model_q.size());
    end else if (off == 2'd1) begin
      if (wd[0]) m_ovf = 1'b0;
      if (wd[1]) m_perr = 1'b0;
    end
    offset = off;
    WLEN   = wl;
    wdata  = wd;
    EN_N   = 1'b0;
    exp_q.push_back(e);
    ready_cyc_q.push_back(cyc + 2);
    valid_from = cyc + 2;
  endtask

  task automatic bus_access(input logic [1:0] off, input logic [1:0] wl, input logic [31:0] wd,
                            input int hold);
    bus_start(off, wl, wd);
    repeat (hold) tick();
    EN_N = 1'b1;
    repeat (2) tick();
  endtask

  task automatic send_raw(input logic [10:0] bits, input int n, input bit coincide);
    frame_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H / 2) tick();
      ps2_clk = 1'b0;
      if (coincide && i == 10) begin
        repeat (2) tick();
        bus_start(2'd0, 2'b00, 32'd0);
        tick();
        EN_N = 1'b1;
        repeat (H - 3) tick();
      end else begin
        repeat (H) tick();
      end
      ps2_clk = 1'b1;
      repeat (H / 2) tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit coincide);
    send_raw({1'b1, (~^b) ^ bad_par, b, 1'b0}, 11, coincide);
    repeat (4) tick();
    if (bad_par) m_perr = 1'b1;
    else if (model_q.size() == DEPTH) m_ovf = 1'b1;
    else model_q.push_back(b);
    frame_busy = 1'b0;
    valid_from = cyc;
  endtask

  task automatic rd(input logic [1:0] off);
    bus_access(off, 2'b00, 32'd0, 1);
  endtask

  initial begin
    RST_N = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    offset = '0; wdata = '0; WLEN = '0; EN_N = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    valid_from = cyc;
    tick();
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ready", {31'b0, READY}, 32'd0);
    rd(2'd1);
    chk("reset_status", last_rdata, 32'h0);

    // single good frame
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("irq_after_push", {31'b0, irq}, 32'd1);
    rd(2'd0);
    chk("lit_data_1c", last_rdata, 32'h0000011C);
    rd(2'd1);
    chk("lit_status_empty", last_rdata, 32'h0);

    // parity error, then clear it
    send_frame(8'h1C, 1'b1, 1'b0);
    rd(2'd1);
    chk("lit_perr", last_rdata, 32'h00000200);
    bus_access(2'd1, 2'b01, 32'd2, 1);
    rd(2'd1);
    chk("lit_perr_clr", last_rdata, 32'h0);

    // overflow
    for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b0);
    rd(2'd1);
    chk("lit_ovf_status", last_rdata, 32'h00000110);
    rd(2'd0);
    chk("lit_first_pop", last_rdata, 32'h00000101);
    for (int i = 1; i < DEPTH; i++) rd(2'd0);
    chk("lit_last_pop", last_rdata, 32'h00000110);
    rd(2'd0);
    chk("lit_empty_pop", last_rdata, 32'h0);
    bus_access(2'd1, 2'b10, 32'd1, 1);
    rd(2'd1);
    chk("lit_ovf_clr", last_rdata, 32'h0);

    // held request gives a single access
    send_frame(8'hA1, 1'b0, 1'b0);
    send_frame(8'hB2, 1'b0, 1'b0);
    bus_access(2'd0, 2'b00, 32'd0, 5);
    chk("lit_hold_data", last_rdata, 32'h000001A1);
    rd(2'd1);
    chk("lit_hold_status", last_rdata, 32'h00000001);
    rd(2'd0);
    chk("lit_hold_drain", last_rdata, 32'h000001B2);

    // reserved offset and data write return zero
    bus_access(2'd3, 2'b00, 32'd0, 1);
    chk("lit_reserved", last_rdata, 32'h0);
    bus_access(2'd0, 2'b11, 32'hFFFF_FFFF, 1);
    chk("lit_data_write", last_rdata, 32'h0);

    // aborted frame then a good one
    send_raw(11'b000_0000_1010, 4, 1'b0);
    repeat (5200) tick();
    frame_busy = 1'b0;
    valid_from = cyc;
    send_frame(8'h5A, 1'b0, 1'b0);
    rd(2'd1);
    chk("lit_timeout_status", last_rdata, 32'h00000001);
    rd(2'd0);
    chk("lit_timeout_data", last_rdata, 32'h0000015A);

    // push coinciding with pop at count=1
    send_frame(8'h21, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("lit_coin1_data", last_rdata, 32'h00000121);
    rd(2'd1);
    chk("lit_coin1_status", last_rdata, 32'h00000001);
    rd(2'd0);
    chk("lit_coin1_drain", last_rdata, 32'h00000122);

    // push coinciding with pop at count=DEPTH
    for (int i = 0; i < DEPTH; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0);
    send_frame(8'h40, 1'b0, 1'b1);
    chk("lit_coin16_data", last_rdata, 32'h00000130);
    rd(2'd1);
    chk("lit_coin16_status", last_rdata, 32'h00000010);
    for (int i = 0; i < DEPTH; i++) rd(2'd0);
    chk("lit_coin16_last", last_rdata, 32'h00000140);

    // reset mid-frame with entries queued
    for (int i = 0; i < 3; i++) send_frame(8'h61 + 8'(i), 1'b0, 1'b0);
    send_raw(11'b000_1100_1100, 5, 1'b0);
    ps2_clk = 1'b0;
    tick();
    RST_N = 1'b0;
    model_q.delete();
    exp_q.delete();
    ready_cyc_q.delete();
    m_ovf = 1'b0;
    m_perr = 1'b0;
    #1;
    chk("lit_rst_ready", {31'b0, READY}, 32'd0);
    chk("lit_rst_irq", {31'b0, irq}, 32'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) tick();
    RST_N = 1'b1;
    frame_busy = 1'b0;
    valid_from = cyc;
    tick();
    rd(2'd1);
    chk("lit_rst_status", last_rdata, 32'h0);
    send_frame(8'h77, 1'b0, 1'b0);
    rd(2'd0);
    chk("lit_rst_frame", last_rdata, 32'h00000177);

    repeat (5) tick();
    chk("pending_ready", 32'(ready_cyc_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
